// File: rtl/store_buffer.sv
// store_buffer: posted-store FIFO between a single-cycle CPU data port and a
// slower req/ack backing memory. Stores are queued and drained in order. A
// load that cannot be served from the buffer triggers one memory read while
// the CPU is stalled.
// Optional feature macro: STORE_FWD_EN. When defined, loads that match a
// buffered store are answered from the youngest matching entry. When it is
// undefined, there is no compare logic: a load waits for the buffer to drain
// completely and is then served by a memory read.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [AW-1:0]            cpu_addr_i,
    input  logic [DW-1:0]            cpu_data_i,
    input  logic                     cpu_we_i,
    input  logic                     cpu_re_i,
    output logic [DW-1:0]            cpu_data_o,
    output logic                     cpu_stall_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [AW-1:0]            mem_addr_o,
    output logic [DW-1:0]            mem_data_o,
    input  logic                     mem_ack_i,
    input  logic [DW-1:0]            mem_rdata_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int WW = AW - 2;
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [PW:0] ONE_C   = (PW+1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        RDONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW:0]     count_q, count_d;

    // Store slots hold word addresses only; byte offsets are irrelevant.
    logic [WW-1:0]   buf_addr_q [DEPTH];
    logic [DW-1:0]   buf_data_q [DEPTH];
    logic [DW-1:0]   rdata_q;

    logic            full, empty;
    logic            store_req, load_req, load_miss;
    logic            push, pop;
    logic            rd_from_idle, rd_after_pop;
    logic [WW-1:0]   cpu_word;

    // Byte offset bits are deliberately ignored (word granularity).
    logic            unused_byte_ofs;
    assign unused_byte_ofs = ^cpu_addr_i[1:0];

    assign cpu_word  = cpu_addr_i[AW-1:2];
    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);

    // A simultaneous store and load is treated as a store.
    assign store_req = cpu_we_i;
    assign load_req  = cpu_re_i && !cpu_we_i;

    // A pop happens only when the memory acknowledges the head write.
    assign pop       = (state_q == WR) && mem_ack_i;

    // When full, the store can still enter in the same cycle the head leaves.
    assign push      = store_req && (!full || pop);

`ifdef STORE_FWD_EN
    logic            load_hit;
    logic [DW-1:0]   fwd_data;

    // Search oldest to youngest so the youngest matching store wins.
    always_comb begin
        load_hit = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (((PW+1)'(i) < count_q) &&
                (buf_addr_q[rd_ptr_q + PW'(i)] == cpu_word)) begin
                load_hit = 1'b1;
                fwd_data = buf_data_q[rd_ptr_q + PW'(i)];
            end
        end
    end

    assign load_miss    = load_req && !load_hit;
    // Memory holds the current value of any word not in the buffer, so a miss
    // may read immediately even with other stores still queued.
    assign rd_from_idle = load_miss;
    assign rd_after_pop = load_miss;
`else
    // Without forwarding every load is served from memory, and only once the
    // buffer is empty so the read observes all older stores.
    assign load_miss    = load_req;
    assign rd_from_idle = load_req && empty;
    assign rd_after_pop = load_req && (count_q == ONE_C);
`endif

    // Stall a store into a full buffer unless a pop frees a slot this cycle;
    // stall a missing load until the cycle its read data is presented.
    always_comb begin
        cpu_stall_o = 1'b0;
        if (store_req && full && !pop) begin
            cpu_stall_o = 1'b1;
        end
        if (load_miss && (state_q != RDONE)) begin
            cpu_stall_o = 1'b1;
        end
    end

    // Load data: latched memory data in RDONE, otherwise a forwarded store.
    always_comb begin
        cpu_data_o = '0;
        if (state_q == RDONE) begin
            cpu_data_o = rdata_q;
        end
`ifdef STORE_FWD_EN
        else if (load_req && load_hit) begin
            cpu_data_o = fwd_data;
        end
`endif
    end

    // Occupancy next state from the push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Transaction FSM: next state and memory-side outputs, one request in flight.
    always_comb begin
        state_d    = state_q;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_data_o = '0;
        case (state_q)
            IDLE: begin
                if (rd_from_idle) begin
                    state_d = RD;
                end else if (!empty) begin
                    state_d = WR;
                end
            end
            WR: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = {buf_addr_q[rd_ptr_q], 2'b00};
                mem_data_o = buf_data_q[rd_ptr_q];
                // A waiting load is never allowed to cut in before this ack.
                if (mem_ack_i) begin
                    if (rd_after_pop) begin
                        state_d = RD;
                    end else if (count_q > ONE_C) begin
                        state_d = WR;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RD: begin
                mem_req_o  = 1'b1;
                // The stalled CPU holds its address, so this stays stable.
                mem_addr_o = {cpu_word, 2'b00};
                if (mem_ack_i) begin
                    state_d = RDONE;
                end
            end
            RDONE: begin
                if (!empty) begin
                    state_d = WR;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers: pointers, occupancy and FSM state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    // Data registers: store slots and the read-return latch (no reset needed).
    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_addr_q[wr_ptr_q] <= cpu_word;
            buf_data_q[wr_ptr_q] <= cpu_data_i;
        end
        if ((state_q == RD) && mem_ack_i) begin
            rdata_q <= mem_rdata_i;
        end
    end

    assign count_o = count_q;

    a_count_range: assert property (@(posedge clk_i) disable iff (rst_i)
        count_q <= DEPTH_C);
    a_no_empty_pop: assert property (@(posedge clk_i) disable iff (rst_i)
        pop |-> !empty);
    a_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
        (mem_req_o && !mem_ack_i) |=> (mem_req_o && $stable(mem_we_o)));

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios with literal expectations plus a
// randomized CPU/memory run checked every cycle against a queue-based model.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk;
    logic          rst_i;
    logic [31:0]   cpu_addr_i, cpu_data_i;
    logic          cpu_we_i, cpu_re_i;
    logic [31:0]   cpu_data_o;
    logic          cpu_stall_o;
    logic          mem_req_o, mem_we_o;
    logic [31:0]   mem_addr_o, mem_data_o;
    logic          mem_ack_i;
    logic [31:0]   mem_rdata_i;
    logic [2:0]    count_o;

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_re_i    (cpu_re_i),
        .cpu_data_o  (cpu_data_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .count_o     (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [29:0] w;
        logic [31:0] d;
    } ent_t;

    int           checks = 0;
    int           failures = 0;

    // Reference model: pending stores in program order and memory contents.
    ent_t         sb_q [$];
    logic [31:0]  mem [logic [29:0]];
    logic         rd_done = 1'b0;
    logic         stall_q = 1'b0;
    int           stall_run = 0;
    logic         prev_req = 1'b0, prev_we = 1'b0, prev_ack = 1'b0;
    logic [31:0]  prev_addr = '0, prev_data = '0;

    // Memory responder: 0 never ack, 1 random delay, 2 ack on any request,
    // 3 ack unconditionally (stray pulses).
    int           ack_mode = 0;
    int           wait_cnt = 0;
    int           ack_dly = 0;

    logic [31:0]  order [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [29:0] w);
        if (mem.exists(w)) return mem[w];
        if (w == 30'h80) return 32'h1234_5678;
        return {2'b00, w} ^ 32'hC0DE_0000;
    endfunction

    task automatic respond();
        logic ack;
        ack = 1'b0;
        case (ack_mode)
            1: begin
                if (mem_req_o) begin
                    if (wait_cnt >= ack_dly) begin
                        ack = 1'b1;
                        wait_cnt = 0;
                        ack_dly = $urandom_range(0, 3);
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    wait_cnt = 0;
                end
            end
            2: ack = mem_req_o;
            3: ack = 1'b1;
            default: ack = 1'b0;
        endcase
        mem_ack_i = ack;
        mem_rdata_i = (ack && mem_req_o && !mem_we_o) ? mem_val(mem_addr_o[31:2]) : $urandom;
    endtask

    // Per-cycle comparison of every DUT output against the model, then the
    // model advances across the coming clock edge.
    task automatic compare_update();
        logic        ld, st, wr_ack, rd_ack, hit, exp_stall, full;
        logic [29:0] w;
        logic [31:0] hit_data, exp_data;
        ent_t        head;
        if (rst_i) begin
            sb_q.delete();
            rd_done = 1'b0;
            prev_req = 1'b0;
            stall_run = 0;
            stall_q = 1'b0;
            return;
        end
        st     = cpu_we_i;
        ld     = cpu_re_i && !cpu_we_i;
        w      = cpu_addr_i[31:2];
        wr_ack = mem_ack_i && mem_req_o && mem_we_o;
        rd_ack = mem_ack_i && mem_req_o && !mem_we_o;
        full   = (sb_q.size() == DEPTH);
        hit = 1'b0;
        hit_data = '0;
`ifdef STORE_FWD_EN
        foreach (sb_q[i]) begin
            if (sb_q[i].w == w) begin
                hit = 1'b1;
                hit_data = sb_q[i].d;
            end
        end
`endif
        chk("count", 64'(count_o), 64'(sb_q.size()));

        if (prev_req && !prev_ack) begin
            chk("req_held", 64'(mem_req_o), 64'd1);
            chk("we_held", 64'(mem_we_o), 64'(prev_we));
            chk("addr_held", 64'(mem_addr_o), 64'(prev_addr));
            if (prev_we) chk("data_held", 64'(mem_data_o), 64'(prev_data));
        end

        if (mem_req_o) begin
            chk("addr_align", 64'(mem_addr_o[1:0]), 64'd0);
            if (mem_we_o) begin
                chk("wr_nonempty", 64'(sb_q.size() > 0), 64'd1);
                if (sb_q.size() > 0) begin
                    head = sb_q[0];
                    chk("wr_addr", 64'(mem_addr_o), 64'({head.w, 2'b00}));
                    chk("wr_data", 64'(mem_data_o), 64'(head.d));
                end
            end else begin
                chk("rd_for_load", 64'(ld), 64'd1);
                chk("rd_addr", 64'(mem_addr_o), 64'({w, 2'b00}));
`ifdef STORE_FWD_EN
                chk("rd_no_hit", 64'(hit), 64'd0);
`else
                chk("rd_after_drain", 64'(sb_q.size()), 64'd0);
`endif
            end
        end

        if (st)      exp_stall = full && !wr_ack;
        else if (ld) exp_stall = hit ? 1'b0 : !rd_done;
        else         exp_stall = 1'b0;
        chk("stall", 64'(cpu_stall_o), 64'(exp_stall));

        if (ld && !exp_stall) begin
            exp_data = hit ? hit_data : mem_val(w);
            chk("load_data", 64'(cpu_data_o), 64'(exp_data));
        end

        if (wr_ack && sb_q.size() > 0) begin
            head = sb_q[0];
            mem[head.w] = head.d;
            void'(sb_q.pop_front());
        end
        if (st && !exp_stall) sb_q.push_back('{w: w, d: cpu_data_i});
        rd_done   = rd_ack;
        prev_req  = mem_req_o;
        prev_we   = mem_we_o;
        prev_addr = mem_addr_o;
        prev_data = mem_data_o;
        prev_ack  = mem_ack_i;
        stall_q   = cpu_stall_o;
        if (cpu_stall_o) stall_run++;
        else stall_run = 0;
        if (stall_run > 40) begin
            chk("stall_bound", 64'(stall_run), 64'd40);
            stall_run = 0;
        end
    endtask

    // One clock cycle: apply inputs after the edge, respond, compare at negedge.
    task automatic drive(input logic r, input logic we, input logic re,
                         input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        rst_i = r;
        cpu_we_i = we;
        cpu_re_i = re;
        cpu_addr_i = a;
        cpu_data_i = d;
        #1;
        respond();
        @(negedge clk);
        compare_update();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic hold_load(input logic [31:0] a);
        for (int i = 0; i < 60 && cpu_stall_o; i++) drive(1'b0, 1'b0, 1'b1, a, 32'h0);
        chk("load_served", 64'(cpu_stall_o), 64'd0);
    endtask

    task automatic load_served(input logic [31:0] a);
        drive(1'b0, 1'b0, 1'b1, a, 32'h0);
        hold_load(a);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (count_o != 0 || mem_req_o); i++) idle();
        chk("drained", 64'(count_o), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

    initial begin
        int nstall, nreq;
        logic [31:0] a;
        int r;
        rst_i = 1'b1;
        cpu_we_i = 1'b0;
        cpu_re_i = 1'b0;
        cpu_addr_i = '0;
        cpu_data_i = '0;
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        ack_dly = $urandom_range(0, 3);

        // Reset for two cycles, then everything is quiet.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_stall", 64'(cpu_stall_o), 64'd0);
        chk("rst_req", 64'(mem_req_o), 64'd0);
        chk("rst_cpu_data", 64'(cpu_data_o), 64'd0);

        // Empty buffer load miss with ack three cycles after the request.
        nstall = 0;
        nreq = 0;
        for (int i = 0; i < 40; i++) begin
            ack_mode = (nreq == 3) ? 2 : 0;
            drive(1'b0, 1'b0, 1'b1, 32'h200, 32'h0);
            if (!cpu_stall_o) break;
            nstall++;
            if (mem_req_o) begin
                nreq++;
                chk("miss_we", 64'(mem_we_o), 64'd0);
                chk("miss_addr", 64'(mem_addr_o), 64'h200);
            end
        end
        chk("miss_data", 64'(cpu_data_o), 64'h1234_5678);
        chk("miss_stall_cycles", 64'(nstall), 64'd5);
        ack_mode = 0;
        idle();

        // Store then immediately load the same word with the memory silent.
        drive(1'b0, 1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF);
        drive(1'b0, 1'b0, 1'b1, 32'h100, 32'h0);
`ifdef STORE_FWD_EN
        chk("fwd_stall", 64'(cpu_stall_o), 64'd0);
        chk("fwd_data", 64'(cpu_data_o), 64'hDEAD_BEEF);
`else
        chk("nofwd_stall", 64'(cpu_stall_o), 64'd1);
        drive(1'b0, 1'b0, 1'b1, 32'h100, 32'h0);
        chk("nofwd_stall_held", 64'(cpu_stall_o), 64'd1);
`endif
        ack_mode = 1;
        hold_load(32'h100);
        chk("st_ld_data", 64'(cpu_data_o), 64'hDEAD_BEEF);
        drain();

        // Two stores to one word: the younger value wins, in buffer and memory.
        ack_mode = 0;
        drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h1);
        drive(1'b0, 1'b1, 1'b0, 32'h42, 32'h2);
        drive(1'b0, 1'b0, 1'b1, 32'h40, 32'h0);
`ifdef STORE_FWD_EN
        chk("young_fwd", 64'(cpu_data_o), 64'h2);
`else
        chk("young_stall", 64'(cpu_stall_o), 64'd1);
`endif
        ack_mode = 1;
        hold_load(32'h40);
        chk("young_data", 64'(cpu_data_o), 64'h2);
        drain();
        load_served(32'h41);
        chk("young_mem", 64'(cpu_data_o), 64'h2);
        idle();

        // Fill, stall on the fifth store, release with one ack pulse.
        ack_mode = 0;
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'hA0 + 32'(i));
        drive(1'b0, 1'b1, 1'b0, 32'h310, 32'hA4);
        chk("full_count", 64'(count_o), 64'd4);
        chk("full_stall", 64'(cpu_stall_o), 64'd1);
        order.delete();
        ack_mode = 2;
        drive(1'b0, 1'b1, 1'b0, 32'h310, 32'hA4);
        chk("pulse_stall", 64'(cpu_stall_o), 64'd0);
        if (mem_req_o && mem_we_o && mem_ack_i) order.push_back(mem_addr_o);
        ack_mode = 0;
        idle();
        chk("pulse_count", 64'(count_o), 64'd4);
        ack_mode = 2;
        for (int i = 0; i < 20 && count_o != 0; i++) begin
            idle();
            if (mem_req_o && mem_we_o && mem_ack_i) order.push_back(mem_addr_o);
        end
        chk("order_len", 64'(order.size()), 64'd5);
        for (int i = 0; i < 5 && i < order.size(); i++)
            chk("fifo_order", 64'(order[i]), 64'(32'h300 + 32'(4 * i)));
        ack_mode = 1;
        drain();
        load_served(32'h310);
        chk("fifth_mem", 64'(cpu_data_o), 64'hA4);
        idle();

        // Reset while writing with two entries; a late ack must do nothing.
        ack_mode = 0;
        drive(1'b0, 1'b1, 1'b0, 32'h500, 32'h55);
        drive(1'b0, 1'b1, 1'b0, 32'h504, 32'h66);
        idle();
        chk("pre_rst_count", 64'(count_o), 64'd2);
        chk("pre_rst_req", 64'(mem_req_o), 64'd1);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();
        chk("post_rst_req", 64'(mem_req_o), 64'd0);
        chk("post_rst_count", 64'(count_o), 64'd0);
        ack_mode = 3;
        for (int i = 0; i < 2; i++) begin
            idle();
            chk("stray_req", 64'(mem_req_o), 64'd0);
            chk("stray_count", 64'(count_o), 64'd0);
        end
        ack_mode = 0;
        idle();
        chk("stray_settled", 64'(mem_req_o), 64'd0);

        // Randomized traffic against the model.
        ack_mode = 1;
        for (int c = 0; c < 1500; c++) begin
            if (stall_q) begin
                drive(1'b0, cpu_we_i, cpu_re_i, cpu_addr_i, cpu_data_i);
            end else begin
                r = $urandom_range(0, 99);
                a = 32'h40 + (32'($urandom_range(0, 5)) << 2) + 32'($urandom_range(0, 3));
                if (r < 40)      drive(1'b0, 1'b1, 1'b0, a, $urandom);
                else if (r < 70) drive(1'b0, 1'b0, 1'b1, a, $urandom);
                else if (r < 75) drive(1'b0, 1'b1, 1'b1, a, $urandom);
                else             idle();
            end
        end
        for (int i = 0; i < 60 && stall_q; i++)
            drive(1'b0, cpu_we_i, cpu_re_i, cpu_addr_i, cpu_data_i);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
